mips_cpu_muldiv: RTL
====================

Name: mips_cpu_muldiv

Overview:
- Iterative multiply/divide sequencer that owns the HI and LO registers.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles. Services MTHI and MTLO writes.
- Driven by the CPU decode stage. busy is the stall indication for MFHI/MFLO and for further mult/div issue.
- Uses one shared 64-bit shift/accumulate datapath, sequenced by an FSM.

Parameters:
WIDTH, 32, operand and HI/LO width. The iteration count equals WIDTH.

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  asynchronous, active-low reset (low clears all state immediately)
clk_enable  input  1  global advance enable; when low, all state is frozen
start  input  1  request a mult/div operation; sampled on enabled edges
op  input  2  operation select, equal to funct[1:0]: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
operand_a  input  WIDTH  Rs value (multiplicand / dividend)
operand_b  input  WIDTH  Rt value (multiplier / divisor)
hi_write  input  1  MTHI strobe
lo_write  input  1  MTLO strobe
write_data  input  WIDTH  data for MTHI/MTLO
busy  output  1  operation in progress; HI/LO not valid
done  output  1  high for exactly one enabled cycle after HI/LO update
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. An in-flight operation is discarded. State is held while reset is low.
- clk_enable low: FSM, counter, accumulators, hi, lo and done hold their values; start and write strobes are ignored.
- FSM states: IDLE, ITER, FIXUP.
- IDLE, start=1 (enabled edge E0):
  - Latch op.
  - For signed ops (op[0]=0), latch |operand_a| and |operand_b|. The magnitude of 0x80000000 is 0x80000000 unsigned.
  - Record neg_res = a[31]^b[31] and neg_rem = a[31]. For unsigned ops both are 0.
  - Clear the 64-bit accumulator, counter=0, go to ITER. busy=1 from after E0.
- ITER: one bit per enabled edge, counter increments. Go to FIXUP when counter=WIDTH-1 (exactly WIDTH ITER edges, E1..E32).
  - Multiply: shift-add, LSB-first. If multiplier bit set, add multiplicand into accumulator upper half; shift right 1 (carry into bit 63).
  - Divide: restoring. Shift {rem,quot} left 1. If rem >= divisor, rem -= divisor and set quot LSB.
- FIXUP (edge E33):
  - Multiply: {hi,lo} = neg_res ? -product : product, as 64-bit two's complement.
  - Divide: lo = neg_res ? -quot : quot; hi = neg_rem ? -rem : rem.
  - done=1 and busy=0 after E33. done clears on the next enabled edge. Return to IDLE.
- Latency: result visible WIDTH+1 = 33 enabled cycles after the start edge.
- Divide by zero (operand_b=0, either signedness): lo=0xFFFFFFFF, hi=operand_a (original, un-negated). Normal latency; same busy/done behaviour.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap).
- start while busy: ignored. No queueing, no error.
- hi_write/lo_write in IDLE with start=0: the register loads write_data on that enabled edge. hi_write and lo_write together load both.
- Write strobes while busy, or in the same cycle as an accepted start: discarded.
- start in the same cycle as FIXUP: ignored. A new op is accepted only from IDLE, one cycle after done asserts.
- hi/lo outputs during busy: keep previous values. Only FIXUP updates them.

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after exactly 33 enabled cycles hi=0xFFFFFFFE, lo=0x00000001; done one-cycle pulse; busy high for 33 cycles.
2. MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
3. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
4. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678.
5. Start MULTU 5*6, drop clk_enable for 5 cycles at ITER cycle 12, assert start and hi_write mid-op -> done after 38 cycles, lo=30, hi=0; start and write discarded.
6. In IDLE: hi_write=1, write_data=0xA5A5A5A5 -> hi=0xA5A5A5A5. Then start DIVU and pull reset low at ITER cycle 10 (between edges) -> busy, done, hi, lo =0 immediately. After release, MULTU 3*4 -> lo=12.

Source files
------------

// File: rtl/mips_cpu_muldiv_if.sv
// Decode-stage <-> multiply/divide unit bus: request, MTHI/MTLO writes,
// and the HI/LO/busy/done results returned to the CPU.
interface mips_cpu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             hi_write;
  logic             lo_write;
  logic [WIDTH-1:0] write_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // CPU side: issues operations and reads HI/LO
  modport master (
    output start, op, operand_a, operand_b, hi_write, lo_write, write_data,
    input  busy, done, hi, lo
  );

  // Multiply/divide unit side
  modport slave (
    input  start, op, operand_a, operand_b, hi_write, lo_write, write_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI and LO.
// One 2*WIDTH-bit accumulator serves both operations: shift-add (LSB-first)
// for multiply, restoring shift-subtract for divide. Signed operations run
// on magnitudes and the signs are applied in a single FIXUP cycle.
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_enable,
  mips_cpu_muldiv_if.slave     bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, FIXUP} state_t;

  state_t               state;
  logic [CNT_W-1:0]     counter;
  logic                 busy_r;
  logic                 done_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;

  // Datapath registers (loaded on accepted start, no reset needed)
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 is_div;
  logic                 div_zero;
  logic                 neg_res;
  logic                 neg_rem;

  logic                 op_signed;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH:0]       rem_diff;
  logic                 rem_ge;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   mul_res;
  logic [WIDTH-1:0]     quot_res;
  logic [WIDTH-1:0]     rem_res;

  // Absolute value; the most negative value maps to itself, which reads
  // correctly as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
    logic signed [WIDTH-1:0] n;
    n = -x;
    return x[WIDTH-1] ? n : x;
  endfunction

  function automatic logic [WIDTH-1:0] negate_if(input logic neg, input logic [WIDTH-1:0] x);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_wide_if(input logic neg,
                                                        input logic [2*WIDTH-1:0] x);
    return neg ? -x : x;
  endfunction

  // Operand conditioning and one iteration step of each algorithm
  always_comb begin
    op_signed = ~bus.op[0];
    a_in      = op_signed ? magnitude(bus.operand_a) : bus.operand_a;
    b_in      = op_signed ? magnitude(bus.operand_b) : bus.operand_b;

    // Multiply: add multiplicand into the upper half, then shift right with
    // the carry landing in the top bit.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_mag[counter] ? {1'b0, a_mag} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};

    // Divide: {rem,quot} shifted left; the shifted remainder needs one extra
    // bit. Since rem < divisor, rem_shift < 2*divisor, so the borrow bit of
    // the subtraction alone tells whether the divisor fits.
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    rem_diff  = rem_shift - {1'b0, b_mag};
    rem_ge    = ~rem_diff[WIDTH];
    div_next  = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                 acc[WIDTH-2:0], rem_ge};

    // Sign fixup. With a zero divisor the remainder ends up equal to |a|,
    // so re-applying a's sign returns the original dividend in HI.
    mul_res   = negate_wide_if(neg_res, acc);
    quot_res  = div_zero ? '1 : negate_if(neg_res, acc[WIDTH-1:0]);
    rem_res   = negate_if(neg_rem, acc[2*WIDTH-1:WIDTH]);
  end

  // Datapath: latch operands/signs on accepted start, step the accumulator in ITER
  always_ff @(posedge clk) begin
    if (clk_enable) begin
      if (state == IDLE && bus.start) begin
        is_div   <= bus.op[1];
        div_zero <= (bus.operand_b == '0);
        a_mag    <= a_in;
        b_mag    <= b_in;
        neg_res  <= op_signed & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
        neg_rem  <= op_signed & bus.operand_a[WIDTH-1];
        // Divide seeds the quotient half with the dividend so its bits
        // shift into the remainder; multiply starts from zero.
        acc      <= bus.op[1] ? {{WIDTH{1'b0}}, a_in} : '0;
      end else if (state == ITER) begin
        acc <= is_div ? div_next : mul_next;
      end
    end
  end

  // Control FSM with registered busy/done and the architectural HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else if (clk_enable) begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= ITER;
            counter <= '0;
            busy_r  <= 1'b1;
          end else begin
            if (bus.hi_write) hi_r <= bus.write_data;
            if (bus.lo_write) lo_r <= bus.write_data;
          end
        end
        ITER: begin
          if (counter == LAST_ITER) begin
            state   <= FIXUP;
            counter <= '0;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        FIXUP: begin
          if (is_div) begin
            hi_r <= rem_res;
            lo_r <= quot_res;
          end else begin
            hi_r <= mul_res[2*WIDTH-1:WIDTH];
            lo_r <= mul_res[WIDTH-1:0];
          end
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule
